// File: rtl/mic_fifo_ext.sv
// mic_fifo_ext: synchronous sample FIFO with occupancy, thresholds, sticky errors, flush and optional FWFT read
module mic_fifo_ext #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 24,
    parameter int FWFT       = 0,
    parameter int AFULL_TH   = 48,
    parameter int AEMPTY_TH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_w_ptr;
    logic [AW:0]           r_r_ptr;
    logic [AW:0]           r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_live;
    logic                  w_wr;
    logic                  w_rd;
    // the extra pointer MSB distinguishes a full ring from an empty one
    always_comb begin
        w_empty = r_w_ptr == r_r_ptr;
        w_full  = (r_w_ptr[AW-1:0] == r_r_ptr[AW-1:0]) && (r_w_ptr[AW] != r_r_ptr[AW]);
        w_live  = !rst && !clr;
        w_wr    = w_live && w_en && !w_full;
        w_rd    = w_live && r_en && !w_empty;
    end
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_w_ptr[AW-1:0]] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_w_ptr     <= '0;
            r_r_ptr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_w_ptr     <= r_w_ptr + (AW+1)'(w_wr);
            r_r_ptr     <= r_r_ptr + (AW+1)'(w_rd);
            r_count     <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
            r_overflow  <= r_overflow  || (w_en && w_full);
            r_underflow <= r_underflow || (r_en && w_empty);
        end
    end
    assign full         = w_full;
    assign empty        = w_empty;
    assign count        = r_count;
    assign almost_full  = r_count >= (AW+1)'(AFULL_TH);
    assign almost_empty = r_count <= (AW+1)'(AEMPTY_TH);
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;
    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = r_mem[r_r_ptr[AW-1:0]];
            assign valid    = !w_empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_data;
            logic                  r_valid;
            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd;
                    if (w_rd) r_data <= r_mem[r_r_ptr[AW-1:0]];
                end
            end
            assign data_out = r_data;
            assign valid    = r_valid;
        end
    endgenerate
endmodule

// File: tb/tb_mic_fifo_ext.sv
// tb_mic_fifo_ext: registered-read and FWFT instances driven in lockstep and checked against a queue model
module tb_mic_fifo_ext;
    localparam int DEPTH = 64;
    localparam int DW    = 24;
    logic          clk = 1'b0;
    logic          rst, clr, w_en, r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] dout0, dout1;
    logic          valid0, full0, empty0, af0, ae0, ovf0, udf0;
    logic          valid1, full1, empty1, af1, ae1, ovf1, udf1;
    logic [6:0]    count0, count1;
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid, m_ovf, m_udf;

    always #5 clk = ~clk;

    mic_fifo_ext #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(0), .AFULL_TH(48), .AEMPTY_TH(16)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout0), .valid(valid0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0));

    mic_fifo_ext #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .FWFT(1), .AFULL_TH(8), .AEMPTY_TH(2)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(dout1), .valid(valid1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model();
        int n;
        n = q.size();
        if (rst || clr) begin
            q.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
        end else begin
            if (w_en && n == DEPTH) m_ovf = 1'b1;
            if (r_en && n == 0) m_udf = 1'b1;
            m_valid = r_en && n > 0;
            if (m_valid) m_dout = q.pop_front();
            if (w_en && n < DEPTH) q.push_back(data_in);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0", 32'(count0), 32'(n));
        chk("count1", 32'(count1), 32'(n));
        chk("full0", 32'(full0), 32'(n == DEPTH));
        chk("empty0", 32'(empty0), 32'(n == 0));
        chk("full1", 32'(full1), 32'(n == DEPTH));
        chk("empty1", 32'(empty1), 32'(n == 0));
        chk("afull0", 32'(af0), 32'(n >= 48));
        chk("aempty0", 32'(ae0), 32'(n <= 16));
        chk("afull1", 32'(af1), 32'(n >= 8));
        chk("aempty1", 32'(ae1), 32'(n <= 2));
        chk("ovf0", 32'(ovf0), 32'(m_ovf));
        chk("udf0", 32'(udf0), 32'(m_udf));
        chk("ovf1", 32'(ovf1), 32'(m_ovf));
        chk("udf1", 32'(udf1), 32'(m_udf));
        chk("valid0", 32'(valid0), 32'(m_valid));
        chk("dout0", 32'(dout0), 32'(m_dout));
        chk("valid1", 32'(valid1), 32'(n > 0));
        if (n > 0) chk("dout1", 32'(dout1), 32'(q[0]));
    endtask

    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c, input logic rs);
        w_en    = w;
        data_in = d;
        r_en    = r;
        clr     = c;
        rst     = rs;
        model();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; w_en = 1'b0; r_en = 1'b0; data_in = '0;
        m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        #2;
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 64; i++) step(1, DW'(i), 0, 0, 0);
        step(1, 24'h000041, 0, 0, 0);
        for (int i = 0; i < 64; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("drain_hold", 32'(dout0), 32'h40);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 200; i++) step(1, DW'($urandom), 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 24'hABCDEF, 0, 0, 0);
        chk("fwft_head", 32'(dout1), 32'hABCDEF);
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 65; i++) step(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 34; i++) step(0, 0, 1, 0, 0);
        step(1, 24'h123456, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, DW'($urandom), 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic w, r, c, rs;
            w  = $urandom_range(0, 99) < ((i / 500) % 2 ? 70 : 40);
            r  = $urandom_range(0, 99) < ((i / 500) % 2 ? 40 : 70);
            c  = $urandom_range(0, 199) == 0;
            rs = $urandom_range(0, 399) == 0;
            step(w, DW'($urandom), r, c, rs);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mic_fifo_ext.md
Name: mic_fifo_ext

Overview:
Parametrised synchronous FIFO for microphone sample streams, successor to the basic mic FIFO.
- Uses all DEPTH entries; full is exact, not DEPTH-1.
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the I2S/PDM capture front end and the feature-extraction pipeline.

Parameters:
DEPTH, 64, number of entries; power of two, >= 4
DATA_WIDTH, 24, sample width in bits
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
AFULL_TH, 48, almost_full asserted when count >= AFULL_TH; range 1..DEPTH
AEMPTY_TH, 16, almost_empty asserted when count <= AEMPTY_TH; range 0..DEPTH-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
clr  input  1  synchronous flush: empties FIFO, clears error flags
w_en  input  1  write request
data_in  input  DATA_WIDTH  write data
r_en  input  1  read request (FWFT=1: acknowledge of head word)
data_out  output  DATA_WIDTH  read data
valid  output  1  data_out holds a newly read word (see Behaviour)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: pointers 0, count 0, data_out 0, valid 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
- Priority: rst > clr > read/write. clr has the same effect as rst on pointers, count, flags, data_out and valid. Storage contents are not cleared. w_en/r_en in a clr cycle are ignored and do not set error flags.
- Pointers: w_ptr and r_ptr are $clog2(DEPTH)+1 bits (extra wrap bit).
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - Address = low bits; pointers wrap naturally at 2*DEPTH.
- Write accepted iff w_en && !full: mem[w_ptr] <= data_in, w_ptr+1.
- Write refused when full, even if a read is accepted the same cycle; a refused write sets overflow.
- Read accepted iff r_en && !empty.
  - Read refused when empty, even if a write occurs the same cycle; a refused read sets underflow.
  - Data written in cycle N is readable in cycle N+1 at the earliest.
- count: +1 on write only, -1 on read only, unchanged when both are accepted. It never exceeds DEPTH or goes below 0.
- full, empty, almost_* are combinational from the registered count/pointers; they update in the cycle after the causing edge.
- FWFT=0:
  - On an accepted read, data_out <= mem[r_ptr] and valid <= 1 on that edge (1-cycle latency).
  - Otherwise valid <= 0 and data_out holds its value.
- FWFT=1:
  - data_out = mem[r_ptr] combinationally; valid = !empty.
  - r_en pops the head. data_out is don't-care while empty.
- overflow/underflow stay 1 until rst or clr.
- Simultaneous read and write at count==1 or count==DEPTH-1 follow the rules above; no bypass path.

Test Plan:
- Reset then fill: rst 1 cycle, write 0x000001..0x000040 (64 words) -> after 64th write full=1, count=64, almost_full=1 since the 48th write; 65th write -> overflow=1, count stays 64.
- Drain, FWFT=0: read 64 times from full -> data_out sequence 0x000001..0x000040, each valid one cycle after its r_en; empty=1 after the last read; 65th r_en -> underflow=1, data_out holds 0x000040, valid=0.
- Wrap-around: 200 cycles of simultaneous w_en/r_en starting from count=5 -> count stays 5, output order matches input order across more than 3 pointer wraps.
- FWFT=1: write 0xABCDEF into an empty FIFO -> next cycle valid=1, data_out=0xABCDEF with no r_en; pulse r_en -> valid=0, empty=1.
- Flush: fill to 30 with overflow previously set, assert clr together with w_en -> next cycle count=0, empty=1, overflow=0, almost_empty=1, nothing written.
- Thresholds: AFULL_TH=8, AEMPTY_TH=2, step count 0..10..0 -> almost_empty=1 for count<=2, almost_full=1 for count>=8, each transitioning exactly on the boundary count.
